// File: rtl/imem_loader_if.sv
// Byte-stream, control and IMEM write-port signals of the instruction-memory loader.
// The master side (host / UART path plus the IMEM port) drives start, len and the byte stream.
// The slave side (the loader) drives the rest.
interface imem_loader_if;
    logic        start;
    logic [31:0] len;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_rst_n;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output start, len, s_valid, s_data,
        input  s_ready, wr_en, wr_addr, wr_data, cpu_rst_n, busy, done, err
    );

    modport slave (
        input  start, len, s_valid, s_data,
        output s_ready, wr_en, wr_addr, wr_data, cpu_rst_n, busy, done, err
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time IMEM loader. It holds the core in reset and packs a byte stream little-endian
// into 32-bit words. It writes one IMEM word per 4 bytes and releases the core reset only
// after a complete, valid load.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing checksum byte.
// With that byte added, the 8-bit payload sum must wrap to zero.
//
// state | meaning
// IDLE  | waiting for start after reset
// RECV  | accepting payload bytes into the word register
// WRITE | one-cycle IMEM word write
// CHK   | accepting the checksum byte (checksum build only)
// DONE  | load good, core reset released
// ERR   | load rejected, core held in reset
module imem_loader #(
    parameter int MEM_NBYTE = 4096
) (
    input  logic          clk,
    input  logic          rst_n,
    imem_loader_if.slave  bus
);

    localparam logic [2:0] STATE_IDLE  = 3'd0;
    localparam logic [2:0] STATE_RECV  = 3'd1;
    localparam logic [2:0] STATE_WRITE = 3'd2;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] STATE_CHK   = 3'd3;
`endif
    localparam logic [2:0] STATE_DONE  = 3'd4;
    localparam logic [2:0] STATE_ERR   = 3'd5;

    // A zero-length load still has to pass through the checksum byte when it is enabled.
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] STATE_END = STATE_CHK;
`else
    localparam logic [2:0] STATE_END = STATE_DONE;
`endif

    logic [2:0]  state_q, state_d;
    logic [31:0] len_q, len_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] word_q, word_d;
    logic        wr_en_q, wr_en_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        cpu_rst_n_q, cpu_rst_n_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  sum_q, sum_d;
`endif

    logic        s_ready;
    logic        accept;
    logic [31:0] word_next;
    logic [31:0] addr_inc;

    // s_ready is the only output decoded directly from state.
    always_comb begin
        s_ready = (state_q == STATE_RECV);
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (state_q == STATE_CHK) s_ready = 1'b1;
`endif
    end

    assign accept   = bus.s_valid && s_ready;
    assign addr_inc = addr_q + 32'd4;

    // Insert the incoming byte into its lane of the word being assembled.
    always_comb begin
        word_next = word_q;
        word_next[{idx_q, 3'b000} +: 8] = bus.s_data;
    end

    // Next-state and datapath logic. The registered outputs follow from state_d.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        addr_d    = addr_q;
        idx_d     = idx_q;
        word_d    = word_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d     = sum_q;
`endif
        case (state_q)
            STATE_IDLE, STATE_DONE, STATE_ERR: begin
                if (bus.start) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d = 8'd0;
`endif
                    if ((bus.len[1:0] != 2'd0) || (bus.len > 32'(MEM_NBYTE))) begin
                        state_d = STATE_ERR;
                    end else if (bus.len == 32'd0) begin
                        state_d = STATE_END;
                    end else begin
                        state_d = STATE_RECV;
                        len_d   = bus.len;
                        addr_d  = 32'd0;
                        idx_d   = 2'd0;
                        word_d  = 32'd0;
                    end
                end
            end
            STATE_RECV: begin
                if (accept) begin
                    word_d = word_next;
                    idx_d  = idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d  = sum_q + bus.s_data;
`endif
                    if (idx_q == 2'd3) begin
                        state_d   = STATE_WRITE;
                        wr_addr_d = addr_q;
                        wr_data_d = word_next;
                    end
                end
            end
            STATE_WRITE: begin
                addr_d  = addr_inc;
                state_d = (addr_inc == len_q) ? STATE_END : STATE_RECV;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            STATE_CHK: begin
                if (accept) begin
                    state_d = ((sum_q + bus.s_data) == 8'd0) ? STATE_DONE : STATE_ERR;
                end
            end
`endif
            default: state_d = STATE_IDLE;
        endcase

        wr_en_d     = (state_d == STATE_WRITE);
        busy_d      = (state_d == STATE_RECV) || (state_d == STATE_WRITE);
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (state_d == STATE_CHK) busy_d = 1'b1;
`endif
        done_d      = (state_d == STATE_DONE);
        err_d       = (state_d == STATE_ERR);
        cpu_rst_n_d = (state_d == STATE_DONE);
    end

    // State and registered outputs. Reset drops straight back to IDLE with the core held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= STATE_IDLE;
            len_q       <= 32'd0;
            addr_q      <= 32'd0;
            idx_q       <= 2'd0;
            word_q      <= 32'd0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= 32'd0;
            wr_data_q   <= 32'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            idx_q       <= idx_d;
            word_q      <= word_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cpu_rst_n_q <= cpu_rst_n_d;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running payload sum for the trailing checksum byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sum_q <= 8'd0;
        else        sum_q <= sum_d;
    end
`endif

    assign bus.s_ready   = s_ready;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.cpu_rst_n = cpu_rst_n_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader. Expected IMEM writes go into a scoreboard when a
// load is set up. A monitor pops and compares them as wr_en pulses.
module tb_imem_loader;
    logic clk;
    logic rst_n;
    imem_loader_if bus ();

    imem_loader #(.MEM_NBYTE(4096)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];

    // Write monitor: checks every wr_en against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.wr_en) begin
                n_cmp++;
                if (exp_addr.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_write: addr=%h data=%h, required no write", bus.wr_addr, bus.wr_data);
                end else begin
                    logic [31:0] ea, ed;
                    ea = exp_addr.pop_front();
                    ed = exp_data.pop_front();
                    if (bus.wr_addr !== ea || bus.wr_data !== ed) begin
                        n_bad++;
                        $display("FAIL write: addr=%h data=%h, required addr=%h data=%h", bus.wr_addr, bus.wr_data, ea, ed);
                    end
                end
                n_cmp++;
                if (bus.s_ready !== 1'b0) begin
                    n_bad++;
                    $display("FAIL wr_en_with_ready: s_ready=%b, required 0", bus.s_ready);
                end
            end
        end
    end

    function automatic logic [7:0] csum_of(input logic [7:0] b[$]);
        logic [7:0] s;
        s = 8'd0;
        foreach (b[i]) s = s + b[i];
        return 8'd0 - s;
    endfunction

    // Expected writes for a byte payload, packed little-endian.
    task automatic push_words(input logic [7:0] b[$]);
        for (int w = 0; w < b.size() / 4; w++) begin
            exp_addr.push_back(32'(w * 4));
            exp_data.push_back({b[w*4+3], b[w*4+2], b[w*4+1], b[w*4]});
        end
    endtask

    task automatic send_bytes(input logic [7:0] b[$], input bit gaps);
        foreach (b[i]) begin
            int g;
            int t;
            bit hs;
            g = gaps ? int'($urandom_range(0, 3)) : 0;
            repeat (g) begin
                @(negedge clk);
                bus.s_valid = 1'b0;
            end
            t = 0;
            hs = 1'b0;
            while (!hs && t < 100) begin
                @(negedge clk);
                bus.s_valid = 1'b1;
                bus.s_data  = b[i];
                hs = bus.s_ready;
                t++;
                @(posedge clk);
            end
            if (!hs) begin
                n_cmp++;
                n_bad++;
                $display("FAIL byte_accept_timeout: byte %0d not accepted, required accept", i);
            end
        end
        @(negedge clk);
        bus.s_valid = 1'b0;
    endtask

    task automatic pulse_start(input logic [31:0] l);
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = l;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_end(input bit exp_done, input string name);
        int t;
        t = 0;
        while (!(bus.done || bus.err) && t < 300) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (bus.done !== exp_done || bus.err !== !exp_done) begin
            n_bad++;
            $display("FAIL %s_end: done=%b err=%b, required done=%b err=%b", name, bus.done, bus.err, exp_done, !exp_done);
        end
        n_cmp++;
        if (bus.cpu_rst_n !== exp_done || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_status: cpu_rst_n=%b busy=%b, required cpu_rst_n=%b busy=0", name, bus.cpu_rst_n, bus.busy, exp_done);
        end
        n_cmp++;
        if (exp_addr.size() != 0) begin
            n_bad++;
            $display("FAIL %s_missing_writes: %0d outstanding, required 0", name, exp_addr.size());
        end
        exp_addr.delete();
        exp_data.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.len = 32'd0;
        bus.s_valid = 1'b0;
        bus.s_data = 8'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus.s_ready, bus.wr_en, bus.wr_addr, bus.wr_data, bus.cpu_rst_n, bus.busy, bus.done, bus.err} !== 70'd0) begin
                n_bad++;
                $display("FAIL reset_idle: rdy=%b we=%b a=%h d=%h crst=%b busy=%b done=%b err=%b, required all 0",
                         bus.s_ready, bus.wr_en, bus.wr_addr, bus.wr_data, bus.cpu_rst_n, bus.busy, bus.done, bus.err);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b[$];
        int done_edge;
        b = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00};
        push_words(b);
`ifdef IMEM_LOADER_CHECKSUM_EN
        b.push_back(csum_of(b));
        done_edge = 12;
`else
        done_edge = 11;
`endif
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = 32'd8;
        fork
            begin
                @(posedge clk);
                #1;
                n_cmp++;
                if (bus.busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL busy_after_start: busy=%b, required 1", bus.busy);
                end
                repeat (done_edge - 2) @(posedge clk);
                #1;
                n_cmp++;
                if (bus.done !== 1'b0 || bus.cpu_rst_n !== 1'b0) begin
                    n_bad++;
                    $display("FAIL done_early: done=%b cpu_rst_n=%b, required 0 0", bus.done, bus.cpu_rst_n);
                end
                @(posedge clk);
                #1;
                n_cmp++;
                if (bus.done !== 1'b1 || bus.cpu_rst_n !== 1'b1) begin
                    n_bad++;
                    $display("FAIL done_latency: done=%b cpu_rst_n=%b, required 1 1", bus.done, bus.cpu_rst_n);
                end
            end
            begin
                @(posedge clk);
                #1;
                bus.start = 1'b0;
                send_bytes(b, 1'b0);
            end
        join
        wait_end(1'b1, "b2b");
    endtask

    task automatic test_gaps();
        logic [7:0] b[$];
        for (int r = 0; r < 3; r++) begin
            b = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00};
            push_words(b);
`ifdef IMEM_LOADER_CHECKSUM_EN
            b.push_back(csum_of(b));
`endif
            pulse_start(32'd8);
            n_cmp++;
            if (bus.cpu_rst_n !== 1'b0) begin
                n_bad++;
                $display("FAIL restart_core_reset: cpu_rst_n=%b, required 0", bus.cpu_rst_n);
            end
            send_bytes(b, 1'b1);
            wait_end(1'b1, "gaps");
        end
    endtask

    task automatic test_bad_len();
        logic [31:0] lens[2];
        logic [7:0] b[$];
        lens = '{32'd6, 32'd4100};
        foreach (lens[k]) begin
            @(negedge clk);
            bus.start = 1'b1;
            bus.len   = lens[k];
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            n_cmp++;
            if (bus.err !== 1'b1 || bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.cpu_rst_n !== 1'b0) begin
                n_bad++;
                $display("FAIL bad_len_%0d: err=%b done=%b busy=%b cpu_rst_n=%b, required 1 0 0 0",
                         lens[k], bus.err, bus.done, bus.busy, bus.cpu_rst_n);
            end
            repeat (5) @(negedge clk);
            wait_end(1'b0, "bad_len");
        end
        b = '{8'haa, 8'hbb, 8'hcc, 8'hdd};
        push_words(b);
`ifdef IMEM_LOADER_CHECKSUM_EN
        b.push_back(csum_of(b));
`endif
        pulse_start(32'd4);
        send_bytes(b, 1'b0);
        wait_end(1'b1, "recover");
    endtask

    task automatic test_mid_reset();
        logic [7:0] b[$];
        b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        exp_addr.push_back(32'd0);
        exp_data.push_back(32'h44332211);
        pulse_start(32'd8);
        send_bytes(b, 1'b0);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.s_ready, bus.wr_en, bus.wr_addr, bus.wr_data, bus.cpu_rst_n, bus.busy, bus.done, bus.err} !== 70'd0) begin
            n_bad++;
            $display("FAIL mid_reset: rdy=%b we=%b a=%h d=%h crst=%b busy=%b done=%b err=%b, required all 0",
                     bus.s_ready, bus.wr_en, bus.wr_addr, bus.wr_data, bus.cpu_rst_n, bus.busy, bus.done, bus.err);
        end
        n_cmp++;
        if (exp_addr.size() != 0) begin
            n_bad++;
            $display("FAIL mid_reset_first_word: %0d outstanding, required 0", exp_addr.size());
        end
        @(negedge clk);
        rst_n = 1'b1;
        b = '{8'hde, 8'had, 8'hbe, 8'hef};
        push_words(b);
`ifdef IMEM_LOADER_CHECKSUM_EN
        b.push_back(csum_of(b));
`endif
        pulse_start(32'd4);
        send_bytes(b, 1'b0);
        wait_end(1'b1, "after_reset");
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] b[$];
        b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hf6};
        exp_addr.push_back(32'd0);
        exp_data.push_back(32'h04030201);
        pulse_start(32'd4);
        send_bytes(b, 1'b0);
        wait_end(1'b1, "csum_good");
        b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hf5};
        exp_addr.push_back(32'd0);
        exp_data.push_back(32'h04030201);
        pulse_start(32'd4);
        send_bytes(b, 1'b0);
        wait_end(1'b0, "csum_bad");
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_bad_len();
        test_mid_reset();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
